// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, RESP} mem_state_t;

   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
   localparam int          CNT_W           = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of quasi-static inputs (switches).
module sync_2ff #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves CPU requests from async SRAM with wait states,
// or from memory-mapped I/O (switches in, hex display out) at IO_ADDR.
module mem_responder
   import mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset_al,
   input  logic        MEM_EN,
   input  logic        WE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic [15:0] SW,
   output logic [15:0] MDR_In,
   output logic        R,
   output logic [15:0] sram_addr,
   output logic [15:0] sram_wdata,
   input  logic [15:0] sram_rdata,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic [15:0] hex_out
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   mem_state_t       state;
   logic [CNT_W-1:0] count;
   logic             we_latched;
   logic [15:0]      sw_sync;

   sync_2ff #(.WIDTH(16)) u_sw_sync (
      .clk   (Clk),
      .rst_n (Reset_al),
      .d     (SW),
      .q     (sw_sync)
   );

   // Every output is a flop; R is raised on the same edge that enters RESP.
   always_ff @(posedge Clk or negedge Reset_al) begin
      if (!Reset_al) begin
         state      <= IDLE;
         count      <= '0;
         we_latched <= 1'b0;
         MDR_In     <= '0;
         R          <= 1'b0;
         hex_out    <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
      end else begin
         R <= 1'b0;
         case (state)
            IDLE: begin
               if (MEM_EN) begin
                  we_latched <= WE;
                  if (MAR == IO_ADDR) begin
                     if (WE) begin
                        hex_out <= MDR;
                     end else begin
                        MDR_In <= sw_sync;
                     end
                     R     <= 1'b1;
                     state <= RESP;
                  end else begin
                     count     <= WAIT_INIT;
                     sram_addr <= MAR;
                     sram_ce_n <= 1'b0;
                     if (WE) begin
                        sram_we_n  <= 1'b0;
                        sram_wdata <= MDR;
                     end else begin
                        sram_oe_n <= 1'b0;
                     end
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (count == '0) begin
                  if (we_latched) begin
                     // Release we_n first; ce_n/addr/data stay for one hold cycle.
                     sram_we_n <= 1'b1;
                     state     <= RECOVER;
                  end else begin
                     MDR_In    <= sram_rdata;
                     sram_ce_n <= 1'b1;
                     sram_oe_n <= 1'b1;
                     R         <= 1'b1;
                     state     <= RESP;
                  end
               end else begin
                  count <= count - 1'b1;
               end
            end
            RECOVER: begin
               sram_ce_n <= 1'b1;
               R         <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance.
module tb_mem_responder;

   logic        Clk = 1'b0;
   logic        Reset_al;
   logic        MEM_EN;
   logic        en0;
   logic        WE;
   logic [15:0] MAR;
   logic [15:0] MDR;
   logic [15:0] SW;

   logic [15:0] mdr_in, s_addr, s_wdata, s_rdata, hex;
   logic        r, ce_n, oe_n, we_n;
   logic [15:0] mdr_in0, s_addr0, s_wdata0, s_rdata0, hex0;
   logic        r0, ce_n0, oe_n0, we_n0;

   int n_err    = 0;
   int n_checks = 0;

   always #5 Clk = ~Clk;

   mem_responder #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut (
      .Clk(Clk), .Reset_al(Reset_al), .MEM_EN(MEM_EN), .WE(WE), .MAR(MAR), .MDR(MDR), .SW(SW),
      .MDR_In(mdr_in), .R(r), .sram_addr(s_addr), .sram_wdata(s_wdata), .sram_rdata(s_rdata),
      .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .hex_out(hex)
   );

   mem_responder #(.WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) dut0 (
      .Clk(Clk), .Reset_al(Reset_al), .MEM_EN(en0), .WE(WE), .MAR(MAR), .MDR(MDR), .SW(SW),
      .MDR_In(mdr_in0), .R(r0), .sram_addr(s_addr0), .sram_wdata(s_wdata0), .sram_rdata(s_rdata0),
      .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0), .hex_out(hex0)
   );

   // SRAM model for the WAIT_CYCLES=2 instance, indexed by the low address byte.
   logic [15:0] mem [0:255];
   bit          init_done = 1'b0;
   always @(posedge Clk) begin
      if (!init_done) begin
         mem[8'h00] <= 16'hBEEF;
         mem[8'h02] <= 16'hCAFE;
         mem[8'h04] <= 16'h7777;
         init_done  <= 1'b1;
      end else if (!ce_n && !we_n) begin
         mem[s_addr[7:0]] <= s_wdata;
      end
   end
   assign s_rdata = (!ce_n && !oe_n) ? mem[s_addr[7:0]] : 16'h0000;

   // The WAIT_CYCLES=0 instance reads back the inverted address.
   assign s_rdata0 = (!ce_n0 && !oe_n0) ? ~s_addr0 : 16'h0000;

   // Issue one request at a negedge; count strobe-low cycles until R (bounded).
   task automatic run_req(input bit sel, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, output int lat, output int ce_cnt,
                          output int oe_cnt, output int we_cnt, output bit mdr_stable,
                          output bit r_after);
      logic [15:0] mdr_start;
      @(negedge Clk);
      mdr_start  = sel ? mdr_in0 : mdr_in;
      WE = wr; MAR = addr; MDR = data;
      if (sel) en0 = 1'b1; else MEM_EN = 1'b1;
      lat = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; mdr_stable = 1'b1;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge Clk);
         if (k == 1) begin
            MAR = 16'h0BAD; MDR = 16'hDEAD; WE = ~wr;
         end
         if (!(sel ? ce_n0 : ce_n)) ce_cnt++;
         if (!(sel ? oe_n0 : oe_n)) oe_cnt++;
         if (!(sel ? we_n0 : we_n)) we_cnt++;
         if ((sel ? mdr_in0 : mdr_in) !== mdr_start) mdr_stable = 1'b0;
         if (sel ? r0 : r) begin
            lat = k; MEM_EN = 1'b0; en0 = 1'b0;
         end
      end
      MEM_EN = 1'b0; en0 = 1'b0;
      @(negedge Clk);
      r_after = sel ? r0 : r;
      $display("req sel=%0d we=%0d addr=%h data=%h lat=%0d ce=%0d oe=%0d we_n=%0d",
               sel, wr, addr, data, lat, ce_cnt, oe_cnt, we_cnt);
   endtask

   task automatic test_sram_read;
      int lat, cc, oc, wc; bit st, ra;
      run_req(1'b0, 1'b0, 16'h3000, 16'h0000, lat, cc, oc, wc, st, ra);
      n_checks++; if (lat !== 4) begin n_err++; $display("FAIL rd_latency: got %0d expected 4", lat); end
      n_checks++; if (cc !== 3 || oc !== 3 || wc !== 0) begin n_err++;
         $display("FAIL rd_strobes: ce=%0d oe=%0d we=%0d expected 3 3 0", cc, oc, wc); end
      n_checks++; if (mdr_in !== 16'hBEEF) begin n_err++; $display("FAIL rd_data: got %h expected beef", mdr_in); end
      n_checks++; if (ra !== 1'b0) begin n_err++; $display("FAIL rd_r_pulse: R still %b after one cycle expected 0", ra); end
   endtask

   task automatic test_sram_write;
      int lat, cc, oc, wc; bit st, ra;
      run_req(1'b0, 1'b1, 16'h3001, 16'h1234, lat, cc, oc, wc, st, ra);
      n_checks++; if (lat !== 5) begin n_err++; $display("FAIL wr_latency: got %0d expected 5", lat); end
      n_checks++; if (wc !== 3 || cc !== 4 || oc !== 0) begin n_err++;
         $display("FAIL wr_strobes: ce=%0d oe=%0d we=%0d expected 4 0 3", cc, oc, wc); end
      n_checks++; if (!st || mdr_in !== 16'hBEEF) begin n_err++;
         $display("FAIL wr_mdr_hold: got %h stable=%0d expected beef stable=1", mdr_in, st); end
      n_checks++; if (mem[8'h01] !== 16'h1234) begin n_err++; $display("FAIL wr_sram_data: got %h expected 1234", mem[8'h01]); end
      run_req(1'b0, 1'b0, 16'h3001, 16'h0000, lat, cc, oc, wc, st, ra);
      n_checks++; if (lat !== 4 || mdr_in !== 16'h1234) begin n_err++;
         $display("FAIL wr_readback: got lat=%0d data=%h expected 4 1234", lat, mdr_in); end
   endtask

   task automatic test_io;
      int lat, cc, oc, wc; bit st, ra;
      SW = 16'h00A5;
      repeat (3) @(negedge Clk);
      run_req(1'b0, 1'b0, 16'hFFFF, 16'h0000, lat, cc, oc, wc, st, ra);
      n_checks++; if (lat !== 1) begin n_err++; $display("FAIL io_rd_latency: got %0d expected 1", lat); end
      n_checks++; if (mdr_in !== 16'h00A5) begin n_err++; $display("FAIL io_rd_data: got %h expected 00a5", mdr_in); end
      n_checks++; if (cc + oc + wc !== 0) begin n_err++; $display("FAIL io_rd_strobe: got %0d strobe cycles expected 0", cc + oc + wc); end
      run_req(1'b0, 1'b1, 16'hFFFF, 16'h0C0D, lat, cc, oc, wc, st, ra);
      n_checks++; if (lat !== 1) begin n_err++; $display("FAIL io_wr_latency: got %0d expected 1", lat); end
      n_checks++; if (hex !== 16'h0C0D) begin n_err++; $display("FAIL io_wr_hex: got %h expected 0c0d", hex); end
      n_checks++; if (!st || cc + oc + wc !== 0) begin n_err++;
         $display("FAIL io_wr_side: stable=%0d strobes=%0d expected 1 0", st, cc + oc + wc); end
   endtask

   task automatic test_reset;
      @(negedge Clk);
      Reset_al = 1'b0;
      #1;
      n_checks++; if (mdr_in !== 16'h0 || r !== 1'b0 || hex !== 16'h0) begin n_err++;
         $display("FAIL rst_outputs: mdr=%h r=%b hex=%h expected 0000 0 0000", mdr_in, r, hex); end
      n_checks++; if (s_addr !== 16'h0 || s_wdata !== 16'h0) begin n_err++;
         $display("FAIL rst_sram_bus: addr=%h wdata=%h expected 0000 0000", s_addr, s_wdata); end
      n_checks++; if ({ce_n, oe_n, we_n} !== 3'b111) begin n_err++;
         $display("FAIL rst_strobes: got %b expected 111", {ce_n, oe_n, we_n}); end
      n_checks++; if (hex0 !== 16'h0 || mdr_in0 !== 16'h0 || s_wdata0 !== 16'h0 || {ce_n0, we_n0} !== 2'b11) begin n_err++;
         $display("FAIL rst_wait0: hex=%h mdr=%h wdata=%h ce/we=%b expected 0 0 0 11", hex0, mdr_in0, s_wdata0, {ce_n0, we_n0}); end
      repeat (2) @(negedge Clk);
      Reset_al = 1'b1;
      repeat (3) @(negedge Clk);
      n_checks++; if (r !== 1'b0 || {ce_n, oe_n, we_n} !== 3'b111) begin n_err++;
         $display("FAIL rst_idle: r=%b strobes=%b expected 0 111", r, {ce_n, oe_n, we_n}); end
      $display("reset pulse done");
   endtask

   task automatic test_back_to_back;
      int r1 = 0, r2 = 0, rcount = 0;
      logic [15:0] d1 = '0, d2 = '0;
      @(negedge Clk);
      WE = 1'b0; MAR = 16'h3000; MEM_EN = 1'b1;
      for (int k = 1; k <= 30 && r2 == 0; k++) begin
         @(negedge Clk);
         if (r) begin
            rcount++;
            if (r1 == 0) begin r1 = k; d1 = mdr_in; MAR = 16'h3002; end
            else begin r2 = k; d2 = mdr_in; MAR = 16'h3004; end
         end
      end
      $display("b2b r1=%0d d1=%h r2=%0d d2=%h", r1, d1, r2, d2);
      n_checks++; if (r1 !== 4 || r2 !== 9 || rcount !== 2) begin n_err++;
         $display("FAIL b2b_timing: r1=%0d r2=%0d n=%0d expected 4 9 2", r1, r2, rcount); end
      n_checks++; if (d1 !== 16'hBEEF || d2 !== 16'hCAFE) begin n_err++;
         $display("FAIL b2b_data: got %h %h expected beef cafe", d1, d2); end
      repeat (2) @(negedge Clk);
      n_checks++; if (ce_n !== 1'b0 || oe_n !== 1'b0) begin n_err++;
         $display("FAIL b2b_third_access: ce=%b oe=%b expected 0 0", ce_n, oe_n); end
      Reset_al = 1'b0; MEM_EN = 1'b0;
      #1;
      n_checks++; if ({ce_n, oe_n, we_n} !== 3'b111 || r !== 1'b0 || mdr_in !== 16'h0 || hex !== 16'h0) begin n_err++;
         $display("FAIL b2b_abort: strobes=%b r=%b mdr=%h hex=%h expected 111 0 0000 0000",
                  {ce_n, oe_n, we_n}, r, mdr_in, hex); end
      repeat (3) @(negedge Clk);
      Reset_al = 1'b1;
      rcount = 0;
      repeat (8) begin
         @(negedge Clk);
         if (r) rcount++;
      end
      n_checks++; if (rcount !== 0) begin n_err++; $display("FAIL b2b_no_r: got %0d R pulses expected 0", rcount); end
   endtask

   task automatic test_wait0;
      int lat, cc, oc, wc; bit st, ra;
      run_req(1'b1, 1'b0, 16'h0010, 16'h0000, lat, cc, oc, wc, st, ra);
      n_checks++; if (lat !== 2 || oc !== 1) begin n_err++;
         $display("FAIL w0_rd_latency: got lat=%0d oe=%0d expected 2 1", lat, oc); end
      n_checks++; if (mdr_in0 !== 16'hFFEF) begin n_err++; $display("FAIL w0_rd_data: got %h expected ffef", mdr_in0); end
      run_req(1'b1, 1'b1, 16'h0020, 16'h5555, lat, cc, oc, wc, st, ra);
      n_checks++; if (lat !== 3 || wc !== 1 || cc !== 2) begin n_err++;
         $display("FAIL w0_wr_latency: got lat=%0d we=%0d ce=%0d expected 3 1 2", lat, wc, cc); end
      n_checks++; if (!st || mdr_in0 !== 16'hFFEF) begin n_err++;
         $display("FAIL w0_wr_mdr_hold: got %h expected ffef", mdr_in0); end
   endtask

   initial begin
      Reset_al = 1'b0; MEM_EN = 1'b0; en0 = 1'b0; WE = 1'b0;
      MAR = 16'h0; MDR = 16'h0; SW = 16'h0;
      repeat (3) @(negedge Clk);
      Reset_al = 1'b1;
      repeat (2) @(negedge Clk);
      test_sram_read;
      test_sram_write;
      test_io;
      test_reset;
      test_back_to_back;
      test_wait0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
